// File: rtl/quad_decoder.sv
// Quadrature decoder behind the A/B capacitive low-pass filters. It keeps a signed 4x position,
// the step direction, the step period in clocks and a saturating count of illegal transitions.
module quad_decoder #(
    parameter int POS_WIDTH    = 32,
    parameter int PERIOD_WIDTH = 24,
    parameter int ERR_WIDTH    = 8
) (
    input  logic                    clock,
    input  logic                    sclr_n,
    input  logic                    a,
    input  logic                    b,
    input  logic                    a_init,
    input  logic                    b_init,
    input  logic                    load,
    input  logic [POS_WIDTH-1:0]    load_value,
    output logic [POS_WIDTH-1:0]    position,
    output logic                    dir,
    output logic                    step,
    output logic                    err,
    output logic [ERR_WIDTH-1:0]    err_count,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    valid
);

    localparam logic [0:0] INIT  = 1'b0;
    localparam logic [0:0] TRACK = 1'b1;

    localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX = '1;
    localparam logic [ERR_WIDTH-1:0]    ERR_MAX    = '1;

    logic [0:0]              state;
    logic [1:0]              prev_ab;
    logic [1:0]              cur_ab;
    logic [PERIOD_WIDTH-1:0] cnt;
    logic [PERIOD_WIDTH-1:0] cnt_inc;
    logic                    fwd;
    logic                    rev;
    logic                    dbl;

    assign cur_ab  = {a, b};
    assign cnt_inc = (cnt == PERIOD_MAX) ? cnt : cnt + 1'b1;
    assign valid   = (state == TRACK);

    // Transition class from {prev_ab, cur_ab}; A leading B counts forward.
    always_comb begin
        fwd = 1'b0;
        rev = 1'b0;
        dbl = 1'b0;
        case ({prev_ab, cur_ab})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: fwd = 1'b1;
            4'b1000, 4'b1110, 4'b0111, 4'b0001: rev = 1'b1;
            4'b0011, 4'b1100, 4'b1001, 4'b0110: dbl = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!sclr_n) begin
            state     <= INIT;
            prev_ab   <= 2'b00;
            cnt       <= '0;
            position  <= '0;
            dir       <= 1'b0;
            step      <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
            period    <= PERIOD_MAX;
        end else begin
            step <= 1'b0;
            err  <= 1'b0;
            case (state)
                INIT: begin
                    // Leaving INIT only snapshots the inputs, so settling never counts as motion.
                    if (!a_init && !b_init) begin
                        state   <= TRACK;
                        prev_ab <= cur_ab;
                        cnt     <= '0;
                    end
                end
                TRACK: begin
                    if (a_init || b_init) begin
                        state  <= INIT;
                        period <= PERIOD_MAX;
                    end else begin
                        prev_ab <= cur_ab;
                        if (fwd || rev) begin
                            step     <= 1'b1;
                            dir      <= fwd;
                            position <= fwd ? position + 1'b1 : position - 1'b1;
                            period   <= cnt_inc;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt_inc;
                            if (cnt_inc == PERIOD_MAX) begin
                                period <= PERIOD_MAX;
                            end
                            if (dbl) begin
                                err <= 1'b1;
                                if (err_count != ERR_MAX) begin
                                    err_count <= err_count + 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state <= INIT;
            endcase
            // Preset wins over a same-edge step's position update.
            if (load) begin
                position <= load_value;
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed scenarios followed by a random walk,
// every cycle compared against a phase-index reference model.
module tb_quad_decoder;

    localparam int PW = 32;
    localparam int TW = 8;
    localparam int EW = 8;
    localparam int PERIOD_MAX = (1 << TW) - 1;
    localparam int ERR_MAX    = (1 << EW) - 1;

    logic          clock = 1'b0;
    logic          sclr_n = 1'b0;
    logic          a = 1'b0;
    logic          b = 1'b0;
    logic          a_init = 1'b1;
    logic          b_init = 1'b1;
    logic          load = 1'b0;
    logic [PW-1:0] load_value = '0;
    logic [PW-1:0] position;
    logic          dir;
    logic          step;
    logic          err;
    logic [EW-1:0] err_count;
    logic [TW-1:0] period;
    logic          valid;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic          m_track;
    logic [1:0]    m_prev;
    logic [PW-1:0] m_pos;
    logic          m_dir;
    logic          m_step;
    logic          m_err;
    int            m_errc;
    int            m_period;
    int            m_cnt;
    logic [PW-1:0] exp_q[$];
    logic [1:0]    seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    quad_decoder #(.POS_WIDTH(PW), .PERIOD_WIDTH(TW), .ERR_WIDTH(EW)) dut (
        .clock(clock), .sclr_n(sclr_n), .a(a), .b(b), .a_init(a_init), .b_init(b_init),
        .load(load), .load_value(load_value), .position(position), .dir(dir), .step(step),
        .err(err), .err_count(err_count), .period(period), .valid(valid)
    );

    always #5 clock = ~clock;

    initial begin
        #2ms;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, expv, $time);
        end
    endtask

    function automatic int phase(input logic [1:0] ab);
        for (int i = 0; i < 4; i++) if (seq[i] == ab) return i;
        return 0;
    endfunction

    function automatic int imin(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    task automatic model_edge();
        int d;
        if (!sclr_n) begin
            m_track = 0; m_prev = 2'b00; m_cnt = 0; m_pos = '0; m_dir = 0;
            m_step = 0; m_err = 0; m_errc = 0; m_period = PERIOD_MAX;
            exp_q.delete();
            return;
        end
        m_step = 0;
        m_err  = 0;
        if (!m_track) begin
            if (!a_init && !b_init) begin
                m_track = 1; m_prev = {a, b}; m_cnt = 0;
            end
        end else if (a_init || b_init) begin
            m_track = 0;
            m_period = PERIOD_MAX;
        end else begin
            d = (phase({a, b}) - phase(m_prev) + 4) % 4;
            if (d == 1 || d == 3) begin
                m_step = 1;
                m_dir = (d == 1);
                m_pos = (d == 1) ? m_pos + 1 : m_pos - 1;
                m_period = imin(m_cnt + 1, PERIOD_MAX);
                m_cnt = 0;
            end else begin
                m_cnt = imin(m_cnt + 1, PERIOD_MAX);
                if (m_cnt == PERIOD_MAX) m_period = PERIOD_MAX;
                if (d == 2) begin
                    m_err = 1;
                    m_errc = imin(m_errc + 1, ERR_MAX);
                end
            end
            m_prev = {a, b};
        end
        if (load) m_pos = load_value;
        if (m_step) exp_q.push_back(m_pos);
    endtask

    task automatic compare();
        check("position", position, m_pos);
        check("dir", dir, m_dir);
        check("step", step, m_step);
        check("err", err, m_err);
        check("err_count", err_count, m_errc);
        check("period", period, m_period);
        check("valid", valid, m_track);
        check("step_err_excl", step & err, 0);
        if (step === 1'b1) begin
            if (exp_q.size() == 0) check("step_unexpected", 1, 0);
            else check("step_pos", position, exp_q.pop_front());
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            model_edge();
            @(negedge clock);
            compare();
        end
    endtask

    task automatic drive_ab(input logic [1:0] ab, input int hold);
        {a, b} = ab;
        tick(hold);
    endtask

    task automatic do_load(input logic [PW-1:0] v);
        load = 1; load_value = v;
        tick(1);
        load = 0;
    endtask

    initial begin
        // Reset and INIT hold
        sclr_n = 0; a_init = 1; b_init = 1;
        tick(2);
        check("rst_period", period, PERIOD_MAX);
        check("rst_pos", position, 0);
        sclr_n = 1;
        tick(10);
        check("init_valid", valid, 0);
        a_init = 0; b_init = 0; {a, b} = 2'b11;
        tick(1);
        check("enter_valid", valid, 1);
        check("enter_step", step, 0);
        check("enter_pos", position, 0);
        check("enter_period", period, PERIOD_MAX);

        // Forward sequence
        drive_ab(2'b01, 1);
        drive_ab(2'b00, 1);
        do_load(0);
        drive_ab(2'b10, 5);
        drive_ab(2'b11, 5);
        drive_ab(2'b01, 5);
        drive_ab(2'b00, 1);
        check("fwd_pos", position, 4);
        check("fwd_dir", dir, 1);
        check("fwd_period", period, 5);
        tick(4);

        // Reverse from 0
        do_load(0);
        drive_ab(2'b01, 1); check("rev1", position, 32'hFFFF_FFFF);
        drive_ab(2'b11, 1); check("rev2", position, 32'hFFFF_FFFE);
        check("rev_period", period, 1);
        drive_ab(2'b10, 1); check("rev3", position, 32'hFFFF_FFFD);
        drive_ab(2'b00, 1); check("rev4", position, 32'hFFFF_FFFC);
        check("rev_dir", dir, 0);
        drive_ab(2'b10, 1); check("fwd_after_rev", position, 32'hFFFF_FFFD);
        check("fwd_after_rev_dir", dir, 1);
        drive_ab(2'b00, 1);

        // Illegal transitions and saturation
        drive_ab(2'b11, 1);
        check("ill_err", err, 1);
        check("ill_cnt", err_count, 1);
        check("ill_pos", position, 32'hFFFF_FFFC);
        tick(1);
        check("ill_pulse", err, 0);
        for (int i = 0; i < 300; i++) drive_ab((i % 2 == 0) ? 2'b00 : 2'b11, 1);
        check("ill_sat", err_count, ERR_MAX);

        // Wrap and load-with-step
        drive_ab(2'b00, 2);
        do_load(32'h7FFF_FFFF);
        drive_ab(2'b10, 1);
        check("wrap_pos", position, 32'h8000_0000);
        do_load(32'h8000_0000);
        drive_ab(2'b00, 1);
        check("wrap_neg", position, 32'h7FFF_FFFF);
        load = 1; load_value = 32'h0000_1234; {a, b} = 2'b10;
        tick(1);
        load = 0;
        check("load_step_pos", position, 32'h1234);
        check("load_step_step", step, 1);

        // Stall
        tick(PERIOD_MAX + 5);
        check("stall_period", period, PERIOD_MAX);

        // Filter re-init while tracking
        do_load(7);
        a_init = 1;
        for (int i = 0; i < 20; i++) begin
            {a, b} = 2'($urandom_range(0, 3));
            tick(1);
        end
        check("reinit_valid", valid, 0);
        check("reinit_pos", position, 7);
        a_init = 0; {a, b} = 2'b01;
        tick(1);
        check("reenter_valid", valid, 1);
        check("reenter_step", step, 0);
        drive_ab(2'b00, 1);
        check("reenter_fwd", position, 8);

        // Random walk
        for (int i = 0; i < 3000; i++) begin
            int r;
            int ph;
            ph = phase({a, b});
            r = $urandom_range(0, 99);
            if (r < 35)      {a, b} = seq[(ph + 1) % 4];
            else if (r < 60) {a, b} = seq[(ph + 3) % 4];
            else if (r < 65) {a, b} = seq[(ph + 2) % 4];
            load = ($urandom_range(0, 49) == 0);
            load_value = $urandom;
            if ($urandom_range(0, 99) == 0) a_init = ~a_init;
            if ($urandom_range(0, 99) == 0) b_init = ~b_init;
            if (a_init && $urandom_range(0, 9) == 0) a_init = 0;
            if (b_init && $urandom_range(0, 9) == 0) b_init = 0;
            sclr_n = ($urandom_range(0, 499) != 0);
            tick(1);
        end
        sclr_n = 1; load = 0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Quadrature decoder stage that directly consumes the outputs of the per-channel capacitive low-pass filters on rotary encoder inputs A and B.
- Tracks a signed 4x-resolution position count and reports direction and per-step pulses.
- Measures the step period in clocks and counts illegal double transitions.
- Waits until both filters report settled before decoding, so power-up or filter-clear glitches never move the position.

Parameters:
POS_WIDTH, 32, width of signed position counter (two's complement)
PERIOD_WIDTH, 24, width of step-period counter/output
ERR_WIDTH, 8, width of saturating illegal-transition counter

Ports:
clock  in  1  system clock, all logic on posedge
sclr_n  in  1  synchronous reset, active low
a  in  1  filtered channel A (filter out)
b  in  1  filtered channel B (filter out)
a_init  in  1  filter A not yet settled (filter init)
b_init  in  1  filter B not yet settled (filter init)
load  in  1  preset position to load_value
load_value  in  POS_WIDTH  preset value, signed
position  out  POS_WIDTH  signed position count
dir  out  1  direction of last legal step, 1=forward, 0=reverse
step  out  1  one-cycle pulse per legal step
err  out  1  one-cycle pulse per illegal transition
err_count  out  ERR_WIDTH  illegal transitions since reset, saturating
period  out  PERIOD_WIDTH  clocks between the last two steps; all-ones = stalled/unknown
valid  out  1  high while in TRACK state

Behaviour:
- sclr_n=0 at a posedge:
  - state<=INIT; position=0; dir=0; step=0; err=0; err_count=0; period=all-ones; valid=0.
  - Internal prev_ab=00; cycle counter cnt=0.
  - Reset has priority over everything, including load.
- States: INIT, TRACK.
  - INIT->TRACK on the edge where a_init=0 and b_init=0.
    - prev_ab<={a,b}; cnt<=0.
    - No step, no err; valid goes 1 the following cycle.
  - TRACK->INIT on any edge where a_init=1 or b_init=1.
    - position, dir, err_count held; period<=all-ones; step and err stay 0.
  - In INIT, a/b are ignored entirely.
- Decode in TRACK: each edge compares cur={a,b} with prev_ab, then prev_ab<=cur.
  - Forward (+1): 00->10, 10->11, 11->01, 01->00 (A leads B). dir<=1.
  - Reverse (-1): the opposite four transitions. dir<=0.
  - cur==prev_ab: no action.
  - Both bits changed (00<->11, 10<->01): err pulse for 1 cycle; err_count+1, saturating at all-ones; position, dir, period unchanged.
  - Legal step: step pulse for 1 cycle.
- Latency: all outputs are registered. A change on a/b sampled at edge n appears on position/step/dir after edge n (visible in cycle n+1). Back-to-back steps on consecutive edges are each counted.
- Position arithmetic: modular two's complement.
  - Max positive +1 wraps to most negative; most negative -1 wraps to max positive.
  - No saturation, no flag.
- load (TRACK or INIT): position<=load_value on that edge.
  - Overrides a same-edge step's position update.
  - The step pulse, dir update and period update still occur.
- Period, in TRACK:
  - cnt increments every edge, saturating at all-ones.
  - On a legal step: period<=min(cnt+1, all-ones); cnt<=0. Steps on consecutive edges give period=1.
  - Once cnt reaches all-ones without a step: period<=all-ones immediately (stall indication).
  - A direction reversal is treated like any other step.
  - Until the first step after entering TRACK, period stays all-ones.
- step and err are never both 1.
- Outside TRACK, step=0 and err=0.

Test Plan:
- Reset then release with a_init=b_init=1 for 10 cycles, then both 0 with {a,b}=11 -> valid=1 one cycle later, position=0, no step, period=all-ones.
- Forward sequence 00,10,11,01,00 in TRACK, each held 5 cycles -> 4 step pulses, dir=1, position=+4, period=5 after the 2nd step onward.
- Reverse sequence from position 0 -> position=-1 (all-ones), -2, -3, -4 on successive steps, dir=0. Then one forward step -> position=-3, dir=1.
- Illegal jump 00->11 -> err 1-cycle pulse, err_count=1, position unchanged. Repeat 300x with ERR_WIDTH=8 -> err_count holds 255.
- load_value=0x7FFFFFFF with load, then a forward step -> position=0x80000000. Load asserted on the same edge as a step -> position=load_value, step=1.
- In TRACK with position=7, assert a_init for 20 cycles while toggling a/b -> valid=0, position stays 7, no step/err. Release -> re-enters TRACK with prev_ab captured and no spurious step.
